// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS-Lite pipeline: stall, flush,
// forwarding selects and run statistics derived from EX/MEM/WB destination shadows.
module pipe_hazard_ctrl #(
    parameter int FORWARD = 0,
    parameter int CNT_W   = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic             ex_branch_taken,
    output logic             stall,
    output logic             flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] hazard_count
);

    typedef struct packed {
        logic       valid;
        logic       has_dest;
        logic [4:0] dest;
        logic       is_load;
        logic       is_halt;
    } shadow_t;

    typedef enum logic [1:0] {ST_RUN, ST_HALTED, ST_DONE} run_state_t;

    run_state_t state;
    shadow_t    ex_q, mem_q, wb_q;
    shadow_t    dec, ex_next;
    logic       stall_q;
    logic       use_rs, use_rt;
    logic       raw_ex, raw_mem, id_active, advance;
    logic [1:0] fa_next, fb_next;
    logic [5:0] opcode;
    logic [4:0] rs, rt, rd;
    logic       unused_bits;

    assign opcode      = id_instr[31:26];
    assign rs          = id_instr[25:21];
    assign rt          = id_instr[20:16];
    assign rd          = id_instr[15:11];
    assign unused_bits = ^{id_instr[10:0], wb_q.has_dest, wb_q.dest, wb_q.is_load};

    function automatic logic hit(input shadow_t e, input logic [4:0] r);
        return e.valid && e.has_dest && (e.dest == r);
    endfunction

    function automatic logic [1:0] near_sel(input logic use_src, input logic [4:0] r,
                                            input shadow_t ex_e, input shadow_t mem_e);
        if (!use_src)         return 2'b00;
        else if (hit(ex_e, r))  return 2'b01;
        else if (hit(mem_e, r)) return 2'b10;
        else                  return 2'b00;
    endfunction

    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        use_rs    = 1'b0;
        use_rt    = 1'b0;
        // Opcodes 0..11 alternate R-type (even, writes rd) and I-type (odd, writes rt).
        if (opcode <= 6'd11) begin
            use_rs       = 1'b1;
            use_rt       = ~opcode[0];
            dec.has_dest = 1'b1;
            dec.dest     = opcode[0] ? rt : rd;
        end else begin
            case (opcode)
                6'd12: begin
                    use_rs       = 1'b1;
                    dec.has_dest = 1'b1;
                    dec.dest     = rt;
                    dec.is_load  = 1'b1;
                end
                6'd13, 6'd15: begin
                    use_rs = 1'b1;
                    use_rt = 1'b1;
                end
                6'd14, 6'd16: use_rs = 1'b1;
                6'd17:        dec.is_halt = 1'b1;
                default:      ;
            endcase
        end
    end

    always_comb begin
        raw_ex    = (use_rs && hit(ex_q, rs)) || (use_rt && hit(ex_q, rt));
        raw_mem   = (use_rs && hit(mem_q, rs)) || (use_rt && hit(mem_q, rt));
        id_active = id_valid && (state == ST_RUN);
        flush     = ex_branch_taken;
        if (FORWARD != 0) stall = id_active && !flush && ex_q.is_load && raw_ex;
        else              stall = id_active && !flush && (raw_ex || raw_mem);
        advance   = id_active && !stall && !flush;
        ex_next   = advance ? dec : '0;
        fa_next   = 2'b00;
        fb_next   = 2'b00;
        if (FORWARD != 0 && advance) begin
            fa_next = near_sel(use_rs, rs, ex_q, mem_q);
            fb_next = near_sel(use_rt, rt, ex_q, mem_q);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_RUN;
            ex_q         <= '0;
            mem_q        <= '0;
            wb_q         <= '0;
            stall_q      <= 1'b0;
            fwd_a_sel    <= 2'b00;
            fwd_b_sel    <= 2'b00;
            done         <= 1'b0;
            cycle_count  <= '0;
            stall_count  <= '0;
            hazard_count <= '0;
        end else begin
            ex_q    <= ex_next;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            stall_q <= stall;
            if (!stall) begin
                fwd_a_sel <= fa_next;
                fwd_b_sel <= fb_next;
            end
            case (state)
                ST_RUN:     if (advance && dec.is_halt) state <= ST_HALTED;
                ST_HALTED: if (wb_q.valid && wb_q.is_halt) begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                default:    state <= ST_DONE;
            endcase
            if (!done)              cycle_count  <= cycle_count + CNT_W'(1);
            if (stall)              stall_count  <= stall_count + CNT_W'(1);
            if (stall && !stall_q)  hazard_count <= hazard_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage MIPS-Lite pipeline (IF/ID/EX/MEM/WB). It sits beside the pipeline datapath and inspects the instruction in ID against shadow copies of the EX, MEM and WB stage destinations. From that it drives the stall, flush and forwarding-mux selects. It also keeps the cycle, stall and data-hazard counters and raises `done` once HALT retires. One parameter selects between the forwarding and non-forwarding pipeline variants.

## Interface
- FORWARD, 0, 0 = no forwarding (RAW stalls until producer reaches WB); 1 = full forwarding (load-use stall only)
- CNT_W, 32, width of all statistics counters
- clock  in  1  pipeline clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset; clears all state immediately
- id_valid  in  1  ID stage holds a valid instruction
- id_instr  in  32  instruction in ID: opcode[31:26], rs[25:21], rt[20:16], rd[15:11]
- ex_branch_taken  in  1  branch/jump in EX resolved taken this cycle
- stall  out  1  combinational; hold PC and IF/ID, insert bubble into EX
- flush  out  1  combinational; squash IF and ID contents
- fwd_a_sel  out  2  registered; EX operand A source: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
- fwd_b_sel  out  2  registered; same encoding for operand B
- done  out  1  registered, sticky; HALT has completed WB
- cycle_count  out  CNT_W  cycles since reset release, frozen at done
- stall_count  out  CNT_W  bubble cycles inserted by stall
- hazard_count  out  CNT_W  RAW hazard events, one per stalled instruction

## Operation
- Opcodes: ADD 0, ADDI 1, SUB 2, SUBI 3, MUL 4, MULI 5, OR 6, ORI 7, AND 8, ANDI 9, XOR 10, XORI 11, LDW 12, STW 13, BZ 14, BEQ 15, JR 16, HALT 17. Any other opcode decodes as a NOP with no sources and no destination.
- Sources:
  - R-type ALU, STW, BEQ read rs and rt.
  - I-type ALU, LDW, BZ, JR read rs.
  - HALT reads nothing.
- Destination:
  - R-type ALU writes rd.
  - I-type ALU and LDW write rt.
  - All others write nothing.
  - R0 is tracked as an ordinary register.
- Shadow pipeline: three entries {valid, has_dest, dest[4:0], is_load, is_halt} for EX, MEM and WB. Each shifts EX→MEM→WB every cycle. The EX entry loads the ID decode, or a bubble on stall, flush, !id_valid or halted.
- The register file writes in the first half-cycle and reads in the second, so a WB producer never causes a hazard.
- FORWARD=0: stall = a source of the ID instruction matches the dest of a valid EX or MEM entry. A dependency on EX costs 2 bubbles; on MEM, 1.
- FORWARD=1: stall = EX entry is_load and its dest matches a source of the ID instruction (1 bubble).
- Forwarding (FORWARD=1 only; sels are 00 when FORWARD=0): when the ID instruction advances into EX, each operand sel is set as follows:
  - 01 if the source matches the old EX entry dest.
  - Else 10 if it matches the old MEM entry dest.
  - Else 00.
  - The nearest producer wins. A bubble advancing sets both sels to 00. Sels hold during stall.
- flush = ex_branch_taken. Flush overrides stall: stall is forced 0 that cycle, the EX entry becomes a bubble, and no stall or hazard is counted.
- HALT: when HALT advances into EX, a halted flag sets. After that, stall = 0 and id_valid is ignored. When the WB entry is_halt, done sets on the next edge.

## Timing
- Reset (async assert): shadows invalid, halted=0, sels=00, done=0, all counters 0. stall and flush follow their inputs (0 with empty shadows and id_valid=0).
- cycle_count increments every edge while reset_n=1 and done=0, including the edge that sets done. It never changes after that.
- stall_count increments each edge where stall=1.
- hazard_count increments on an edge where stall=1 and stall was 0 on the previous edge.
- Counters wrap modulo 2^CNT_W.
- Reset asserted mid-stall or mid-drain aborts immediately. Counting restarts from 0.

## Test plan
- FORWARD=0, ADD R3,R1,R2 then SUB R5,R3,R4 back-to-back -> stall high 2 cycles; stall_count=2, hazard_count=1.
- FORWARD=0, ADD R3,.. ; OR R9,R8,R7 ; AND R6,R3,R1 -> 1 stall cycle; hazard_count=1.
- FORWARD=1, ADD R3,R1,R2 ; SUB R5,R3,R4 -> no stall; SUB in EX sees fwd_a_sel=01. With one independent instruction between them, fwd_a_sel=10.
- FORWARD=1, LDW R2,0(R1) ; ADD R4,R2,R2 -> 1 stall. ADD in EX then has fwd_a_sel=fwd_b_sel=10. stall_count=1.
- Taken BEQ in EX while ID holds a dependent instruction that would stall -> flush=1, stall=0, stall_count unchanged, EX gets a bubble.
- HALT after 5 instructions, no hazards -> done rises 4 edges after HALT is in ID. cycle_count frozen afterwards. reset_n pulse low clears done and all counters.
